// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [BCD_W-1:0] SAT_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Decimal digits needed to hold any in_w-bit unsigned value.
    function automatic int unsigned int_digs(input int unsigned in_w);
        return (in_w + 2) / 3;
    endfunction

endpackage

// File: rtl/bcd_seq_converter_if.sv
// Input/output handshake bundle between the result register, the converter and the display scan logic.
interface bcd_seq_converter_if
    import bcd_pkg::*;
#(
    parameter int unsigned IN_W = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_bin;
    logic             out_valid;
    logic             out_ready;
    logic [BCD_W-1:0] bcd3;
    logic [BCD_W-1:0] bcd2;
    logic [BCD_W-1:0] bcd1;
    logic [BCD_W-1:0] bcd0;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, in_bin, out_ready,
        input  in_ready, out_valid, bcd3, bcd2, bcd1, bcd0, ovf, busy
    );

    modport slave (
        input  in_valid, in_bin, out_ready,
        output in_ready, out_valid, bcd3, bcd2, bcd1, bcd0, ovf, busy
    );

endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the next left shift.
module bcd_add3_digit
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    output logic [BCD_W-1:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= BCD_W'(5)) begin
            o_digit = i_digit + BCD_W'(3);
        end
    end

endmodule

// File: rtl/bcd_seq_converter.sv
// Multi-cycle shift-add-3 binary-to-BCD converter with valid/ready handshakes on both sides.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int unsigned IN_W     = 16,
    parameter int unsigned OUT_DIGS = 4,
    parameter int unsigned SAT      = 1
) (
    input  logic                clk,
    input  logic                rst,
    bcd_seq_converter_if.slave  bus
);

    localparam int unsigned INT_DIGS = int_digs(IN_W);
    localparam int unsigned SR_W     = INT_DIGS * BCD_W + IN_W;
    localparam int unsigned CNT_W    = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int unsigned RES_W    = 4 * BCD_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SR_W-1:0]   r_sr;
    logic [SR_W-1:0]   w_sr_adj;
    logic [SR_W-1:0]   w_sr_nxt;
    logic              w_carry;
    logic [CNT_W-1:0]  r_cnt;
    logic [RES_W-1:0]  r_bcd;
    logic [RES_W-1:0]  w_bcd_res;
    logic              r_ovf;
    logic              w_ovf_res;
    logic              w_last;

    // Binary part passes through; each decimal digit above it gets its add-3 cell.
    assign w_sr_adj[IN_W-1:0] = r_sr[IN_W-1:0];

    for (genvar g = 0; g < INT_DIGS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .i_digit (r_sr[IN_W + g*BCD_W +: BCD_W]),
            .o_digit (w_sr_adj[IN_W + g*BCD_W +: BCD_W])
        );
    end

    always_comb begin
        {w_carry, w_sr_nxt} = {w_sr_adj, 1'b0};
    end

    assign w_last = (r_cnt == CNT_LAST);

    // Any non-zero digit above the displayed ones is an overflow; the carry
    // out of the top digit cannot occur but is folded in for completeness.
    always_comb begin
        w_ovf_res = w_carry;
        for (int unsigned k = OUT_DIGS; k < INT_DIGS; k++) begin
            w_ovf_res = w_ovf_res | (|w_sr_nxt[IN_W + k*BCD_W +: BCD_W]);
        end
    end

    always_comb begin
        w_bcd_res = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (k < OUT_DIGS) begin
                if ((SAT != 0) && w_ovf_res) begin
                    w_bcd_res[k*BCD_W +: BCD_W] = SAT_DIGIT;
                end else begin
                    w_bcd_res[k*BCD_W +: BCD_W] = w_sr_nxt[IN_W + k*BCD_W +: BCD_W];
                end
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bus.busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == ST_IDLE) && bus.in_valid) begin
                r_sr  <= SR_W'(bus.in_bin);
                r_cnt <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_sr <= w_sr_nxt;
                if (w_last) begin
                    r_cnt <= '0;
                    r_bcd <= w_bcd_res;
                    r_ovf <= w_ovf_res;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.bcd3 = r_bcd[3*BCD_W +: BCD_W];
    assign bus.bcd2 = r_bcd[2*BCD_W +: BCD_W];
    assign bus.bcd1 = r_bcd[1*BCD_W +: BCD_W];
    assign bus.bcd0 = r_bcd[0*BCD_W +: BCD_W];
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Bench for bcd_seq_converter: saturating and modulo instances driven in lockstep against a cycle-level reference.
module tb_bcd_seq_converter;

    localparam int unsigned IN_W = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [IN_W-1:0] in_bin = '0;

    always #5 clk = ~clk;

    bcd_seq_converter_if #(.IN_W(IN_W)) bus_s ();
    bcd_seq_converter_if #(.IN_W(IN_W)) bus_n ();

    assign bus_s.in_valid  = in_valid;
    assign bus_s.in_bin    = in_bin;
    assign bus_s.out_ready = out_ready;
    assign bus_n.in_valid  = in_valid;
    assign bus_n.in_bin    = in_bin;
    assign bus_n.out_ready = out_ready;

    bcd_seq_converter #(.IN_W(IN_W), .OUT_DIGS(4), .SAT(1)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    bcd_seq_converter #(.IN_W(IN_W), .OUT_DIGS(4), .SAT(0)) u_mod (
        .clk (clk),
        .rst (rst),
        .bus (bus_n)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] to_bcd(input int unsigned v);
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'((v / 1000) % 10);
        d2 = 4'((v / 100) % 10);
        d1 = 4'((v / 10) % 10);
        d0 = 4'(v % 10);
        return {d3, d2, d1, d0};
    endfunction

    function automatic logic [15:0] exp_sat(input int unsigned v);
        return (v > 9999) ? 16'h9999 : to_bcd(v);
    endfunction

    function automatic logic [15:0] exp_mod(input int unsigned v);
        return to_bcd(v % 10000);
    endfunction

    function automatic logic [15:0] dig_s();
        return {bus_s.bcd3, bus_s.bcd2, bus_s.bcd1, bus_s.bcd0};
    endfunction

    function automatic logic [15:0] dig_n();
        return {bus_n.bcd3, bus_n.bcd2, bus_n.bcd1, bus_n.bcd0};
    endfunction

    // Reference: a value is accepted when idle, becomes visible after IN_W
    // busy cycles, and is held until taken.
    bit          mon_on = 1'b0;
    bit          m_ready = 1'b1;
    bit          m_valid = 1'b0;
    int          m_rem = 0;
    int unsigned m_val = 0;
    logic [15:0] m_ds = '0;
    logic [15:0] m_dn = '0;
    bit          m_ovf = 1'b0;
    int          n_done = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            chk("sat_handshake", {bus_s.in_ready, bus_s.out_valid, bus_s.busy},
                {m_ready, m_valid, !m_ready && !m_valid});
            chk("mod_handshake", {bus_n.in_ready, bus_n.out_valid, bus_n.busy},
                {m_ready, m_valid, !m_ready && !m_valid});
            chk("sat_digits", dig_s(), m_ds);
            chk("mod_digits", dig_n(), m_dn);
            chk("sat_ovf", bus_s.ovf, m_ovf);
            chk("mod_ovf", bus_n.ovf, m_ovf);
        end
        if (rst) begin
            m_ready = 1'b1;
            m_valid = 1'b0;
            m_rem   = 0;
            m_ds    = '0;
            m_dn    = '0;
            m_ovf   = 1'b0;
        end else if (m_ready) begin
            if (in_valid) begin
                m_ready = 1'b0;
                m_rem   = IN_W;
                m_val   = in_bin;
            end
        end else if (!m_valid) begin
            m_rem--;
            if (m_rem == 0) begin
                m_valid = 1'b1;
                m_ds    = exp_sat(m_val);
                m_dn    = exp_mod(m_val);
                m_ovf   = (m_val > 9999);
            end
        end else if (out_ready) begin
            m_valid = 1'b0;
            m_ready = 1'b1;
            n_done++;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!bus_s.out_valid && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic send(input int unsigned v, output int lat);
        int guard;
        guard = 0;
        while (!bus_s.in_ready && guard < 100) begin
            step();
            guard++;
        end
        chk("send_ready_timeout", guard < 100, 1);
        in_valid = 1'b1;
        in_bin   = IN_W'(v);
        step();
        in_valid = 1'b0;
        wait_done(lat);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic directed(input int unsigned v, input logic [15:0] es, input logic [15:0] en, input bit eovf);
        int lat;
        send(v, lat);
        chk($sformatf("latency_%0d", v), lat, 17);
        chk($sformatf("sat_digits_%0d", v), dig_s(), es);
        chk($sformatf("mod_digits_%0d", v), dig_n(), en);
        chk($sformatf("sat_ovf_%0d", v), bus_s.ovf, eovf);
        chk($sformatf("mod_ovf_%0d", v), bus_n.ovf, eovf);
        take_result();
    endtask

    function automatic logic [IN_W-1:0] rand_val();
        case ($urandom_range(3))
            0:       return IN_W'($urandom_range(10100, 9900));
            1:       return IN_W'($urandom_range(999));
            default: return IN_W'($urandom);
        endcase
    endfunction

    initial begin
        int lat;
        int cyc;
        int target;

        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        mon_on = 1'b1;
        chk("rst_state", {bus_s.in_ready, bus_s.out_valid, bus_s.busy, bus_s.ovf}, 4'b1000);
        chk("rst_digits", dig_s(), 16'h0000);

        directed(1234,  16'h1234, 16'h1234, 1'b0);
        directed(0,     16'h0000, 16'h0000, 1'b0);
        directed(9999,  16'h9999, 16'h9999, 1'b0);
        directed(10,    16'h0010, 16'h0010, 1'b0);
        directed(10000, 16'h9999, 16'h0000, 1'b1);
        directed(65535, 16'h9999, 16'h5535, 1'b1);

        // Result held under back-pressure; a value offered meanwhile is not taken.
        send(5678, lat);
        chk("stall_latency", lat, 17);
        in_valid = 1'b1;
        in_bin   = 16'd77;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_out_valid", bus_s.out_valid, 1);
            chk("stall_in_ready", bus_s.in_ready, 0);
            chk("stall_digits", dig_s(), 16'h5678);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("release_idle", {bus_s.in_ready, bus_s.out_valid}, 2'b10);
        step();
        in_valid = 1'b0;
        chk("accept_77_busy", bus_s.busy, 1);
        wait_done(lat);
        chk("latency_77", lat, 17);
        chk("digits_77", dig_s(), 16'h0077);
        take_result();

        // Reset while the counter is at 7.
        in_valid = 1'b1;
        in_bin   = 16'd5555;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_state", {bus_s.in_ready, bus_s.out_valid, bus_s.busy, bus_s.ovf}, 4'b1000);
        chk("midrst_digits", dig_s(), 16'h0000);
        directed(42, 16'h0042, 16'h0042, 1'b0);

        cyc    = 0;
        target = n_done + 2000;
        while (n_done < target && cyc < 70000) begin
            in_valid  = ($urandom_range(3) != 0);
            in_bin    = rand_val();
            out_ready = ($urandom_range(1) == 1);
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("random_completed", n_done >= target, 1);

        repeat (2) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
